sha256_nonce_dispatch: RTL and testbench

SHA256_NONCE_DISPATCH -- requirements
Module: sha256_nonce_dispatch

---
 rtl/sha256_pkg.sv | 17 +
 rtl/sha256_target_cmp.sv | 15 +
 rtl/sha256_nonce_dispatch.sv | 179 +++++++++++++++++
 tb/tb_sha256_nonce_dispatch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared widths and FSM state type for the SHA-256 nonce dispatcher.
// Nothing here depends on the optional SHA256_DISPATCH_ABORT_EN build macro.
package sha256_pkg;

  localparam int unsigned NonceW  = 32;
  localparam int unsigned HeaderW = 64;
  localparam int unsigned DigestW = 256;
  localparam int unsigned MsgW    = HeaderW + NonceW;

  typedef enum logic [1:0] {
    eIdle,
    eIssue,
    eCollect,
    eDone
  } state_e;

endpackage

// File: rtl/sha256_target_cmp.sv
// Combinational 256-bit unsigned less-than: lt_o = digest_i < target_i.
// The MSB is bit 255.
module sha256_target_cmp
  import sha256_pkg::*;
(
  input  logic [DigestW-1:0] digest_i,
  input  logic [DigestW-1:0] target_i,
  output logic               lt_o
);

  always_comb begin
    lt_o = (digest_i < target_i);
  end

endmodule

// File: rtl/sha256_nonce_dispatch.sv
// Splits a nonce range into batches of core_size messages, collects digests, reports the first hit.
// Optional build macro SHA256_DISPATCH_ABORT_EN adds the abort_i port and its logic.
module sha256_nonce_dispatch
  import sha256_pkg::*;
#(
  parameter int unsigned core_size = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
`ifdef SHA256_DISPATCH_ABORT_EN
  input  logic               abort_i,
`endif
  input  logic               start_i,
  input  logic [HeaderW-1:0] header_i,
  input  logic [NonceW-1:0]  nonce_start_i,
  input  logic [NonceW-1:0]  nonce_count_i,
  input  logic [DigestW-1:0] target_i,
  output logic               v_o,
  output logic [MsgW-1:0]    data_o,
  input  logic               ready_i,
  input  logic               v_i,
  input  logic [DigestW-1:0] data_i,
  output logic               yumi_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               found_o,
  output logic [NonceW-1:0]  nonce_o
);

  localparam int unsigned    IdxW    = (core_size > 1) ? $clog2(core_size) : 1;
  localparam logic [IdxW-1:0]   LastIdx = IdxW'(core_size - 1);
  localparam logic [NonceW-1:0] Batch   = NonceW'(core_size);

  state_e               state_q, state_d;
  logic [HeaderW-1:0]   header_q, header_d;
  logic [DigestW-1:0]   target_q, target_d;
  logic [NonceW-1:0]    base_q, base_d;
  logic [NonceW-1:0]    remain_q, remain_d;
  logic [IdxW-1:0]      k_q, k_d;
  logic [IdxW-1:0]      j_q, j_d;
  logic                 hit_q, hit_d;
  logic [NonceW-1:0]    hit_nonce_q, hit_nonce_d;
  logic                 found_q, found_d;
  logic [NonceW-1:0]    nonce_q, nonce_d;
  logic                 v_q, busy_q, done_q;

  logic                 digest_lt;
  logic [NonceW-1:0]    remain_eff;

  sha256_target_cmp u_target_cmp (
    .digest_i (data_i),
    .target_i (target_q),
    .lt_o     (digest_lt)
  );

  always_comb begin
    remain_eff = remain_q;
`ifdef SHA256_DISPATCH_ABORT_EN
    // Aborting zeroes the range: in-flight messages still complete as padding but cannot hit.
    if (abort_i && (state_q == eIssue || state_q == eCollect)) begin
      remain_eff = '0;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    header_d    = header_q;
    target_d    = target_q;
    base_d      = base_q;
    remain_d    = remain_eff;
    k_d         = k_q;
    j_d         = j_q;
    hit_d       = hit_q;
    hit_nonce_d = hit_nonce_q;
    found_d     = found_q;
    nonce_d     = nonce_q;

    unique case (state_q)
      eIdle, eDone: begin
        if (start_i) begin
          header_d    = header_i;
          target_d    = target_i;
          base_d      = nonce_start_i;
          remain_d    = nonce_count_i;
          k_d         = '0;
          j_d         = '0;
          hit_d       = 1'b0;
          hit_nonce_d = '0;
          found_d     = 1'b0;
          nonce_d     = '0;
          state_d     = (nonce_count_i != '0) ? eIssue : eDone;
        end
      end

      eIssue: begin
        if (ready_i) begin
          k_d = k_q + IdxW'(1);
          if (k_q == LastIdx) begin
            k_d     = '0;
            j_d     = '0;
            state_d = eCollect;
          end
        end
      end

      eCollect: begin
        if (v_i) begin
          j_d = j_q + IdxW'(1);
          // Only the first in-range hit of the batch is kept.
          if (!hit_q && digest_lt && (NonceW'(j_q) < remain_eff)) begin
            hit_d       = 1'b1;
            hit_nonce_d = base_q + NonceW'(j_q);
          end
          if (j_q == LastIdx) begin
            j_d = '0;
            if (hit_d || (remain_eff <= Batch)) begin
              found_d = hit_d;
              nonce_d = hit_d ? hit_nonce_d : '0;
              state_d = eDone;
            end else begin
              remain_d = remain_eff - Batch;
              base_d   = base_q + Batch;
              k_d      = '0;
              state_d  = eIssue;
            end
          end
        end
      end

      default: state_d = eIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= eIdle;
      header_q    <= '0;
      target_q    <= '0;
      base_q      <= '0;
      remain_q    <= '0;
      k_q         <= '0;
      j_q         <= '0;
      hit_q       <= 1'b0;
      hit_nonce_q <= '0;
      found_q     <= 1'b0;
      nonce_q     <= '0;
      v_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      header_q    <= header_d;
      target_q    <= target_d;
      base_q      <= base_d;
      remain_q    <= remain_d;
      k_q         <= k_d;
      j_q         <= j_d;
      hit_q       <= hit_d;
      hit_nonce_q <= hit_nonce_d;
      found_q     <= found_d;
      nonce_q     <= nonce_d;
      v_q         <= (state_d == eIssue);
      busy_q      <= (state_d == eIssue) || (state_d == eCollect);
      done_q      <= (state_d == eDone);
    end
  end

  always_comb begin
    v_o     = v_q;
    data_o  = {header_q, base_q + NonceW'(k_q)};
    yumi_o  = (state_q == eCollect) && v_i;
    busy_o  = busy_q;
    done_o  = done_q;
    found_o = found_q;
    nonce_o = nonce_q;
  end

endmodule

// File: tb/tb_sha256_nonce_dispatch.sv
// Randomised bench for sha256_nonce_dispatch: a downstream model answers each message with a digest
// chosen from a hit list, and a batch-level reference predicts the job outcome.
module tb_sha256_nonce_dispatch;

  localparam int unsigned CoreSize = 4;

  logic         clk_i = 1'b0;
  logic         reset_i, start_i, ready_i, v_i;
  logic [63:0]  header_i;
  logic [31:0]  nonce_start_i, nonce_count_i;
  logic [255:0] target_i, data_i;
  logic         v_o, yumi_o, busy_o, done_o, found_o;
  logic [95:0]  data_o;
  logic [31:0]  nonce_o;
`ifdef SHA256_DISPATCH_ABORT_EN
  logic         abort_i = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  sha256_nonce_dispatch #(
    .core_size (CoreSize)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
`ifdef SHA256_DISPATCH_ABORT_EN
    .abort_i       (abort_i),
`endif
    .start_i       (start_i),
    .header_i      (header_i),
    .nonce_start_i (nonce_start_i),
    .nonce_count_i (nonce_count_i),
    .target_i      (target_i),
    .v_o           (v_o),
    .data_o        (data_o),
    .ready_i       (ready_i),
    .v_i           (v_i),
    .data_i        (data_i),
    .yumi_o        (yumi_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .found_o       (found_o),
    .nonce_o       (nonce_o)
  );

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  logic [31:0]  hits[$];
  logic [255:0] tgt;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_hit(input logic [31:0] n);
    foreach (hits[i]) if (hits[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  // Hits sit just below the target, misses at or just above it.
  function automatic logic [255:0] digest_for(input logic [31:0] n);
    if (is_hit(n)) return tgt - 256'($urandom_range(1, 1000));
    return tgt + 256'($urandom_range(0, 1000));
  endfunction

  // Batch-level outcome: whole batches of CoreSize, first in-range hit wins.
  function automatic void model(input logic [31:0] base, input logic [31:0] count,
                                output bit f, output logic [31:0] n, output int msgs);
    longint unsigned off;
    f = 1'b0;
    n = '0;
    msgs = 0;
    for (off = 0; off < longint'(count); off += CoreSize) begin
      msgs += CoreSize;
      for (int j = 0; j < CoreSize; j++) begin
        if (off + j < count && is_hit(32'(base + 32'(off) + 32'(j)))) begin
          f = 1'b1;
          n = 32'(base + 32'(off) + 32'(j));
          return;
        end
      end
    end
  endfunction

  task automatic new_target();
    for (int i = 0; i < 8; i++) tgt[i*32 +: 32] = $urandom;
    tgt[255:252] = 4'h8;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_v"}, v_o, 1'b0);
    check({tag, "_yumi"}, yumi_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_found"}, found_o, 1'b0);
    check({tag, "_nonce"}, nonce_o, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    reset_i = 1'b0;
    start_i = 1'b0;
    ready_i = 1'b0;
    v_i     = 1'b1;
    repeat (2) @(negedge clk_i);
    check_idle_outputs(tag);
    v_i     = 1'b0;
    reset_i = 1'b1;
  endtask

  task automatic run_job(input string tag, input logic [31:0] base, input logic [31:0] count,
                         input bit stall);
    bit           exp_found;
    logic [31:0]  exp_nonce;
    int           exp_msgs;
    int           issued, collected, cycles;
    logic [31:0]  pend_n[$];
    logic [255:0] pend_d[$];
    bit           held;
    logic [95:0]  held_data;
    logic [63:0]  hdr;

    hdr = {$urandom, $urandom};
    model(base, count, exp_found, exp_nonce, exp_msgs);
    @(negedge clk_i);
    start_i = 1'b1;
    header_i = hdr;
    nonce_start_i = base;
    nonce_count_i = count;
    target_i = tgt;
    ready_i = 1'b0;
    v_i = 1'b0;
    @(negedge clk_i);
    // Scramble job inputs: the DUT must work from latched copies.
    start_i = 1'b0;
    header_i = {$urandom, $urandom};
    nonce_start_i = $urandom;
    target_i = '0;
    issued = 0;
    collected = 0;
    held = 1'b0;
    held_data = '0;
    for (cycles = 0; cycles < 4000 && !done_o; cycles++) begin
      if (held) begin
        check({tag, "_hold_v"}, v_o, 1'b1);
        check({tag, "_hold_data"}, data_o, held_data);
      end
      ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      v_i = (pend_n.size() > 0) && (!stall || $urandom_range(0, 1) == 1);
      data_i = (pend_d.size() > 0) ? pend_d[0] : '0;
      start_i = ($urandom_range(0, 7) == 0);
      nonce_count_i = $urandom_range(0, 3);
      #1;
      held = v_o && !ready_i;
      held_data = data_o;
      if (v_o && v_i) check({tag, "_yumi_in_issue"}, yumi_o, 1'b0);
      if (v_o && ready_i) begin
        check({tag, "_data"}, data_o, {hdr, 32'(base + 32'(issued))});
        pend_n.push_back(32'(base + 32'(issued)));
        pend_d.push_back(digest_for(32'(base + 32'(issued))));
        issued++;
      end
      if (v_i && yumi_o) begin
        void'(pend_n.pop_front());
        void'(pend_d.pop_front());
        collected++;
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    v_i = 1'b0;
    check({tag, "_done"}, done_o, 1'b1);
    check({tag, "_found"}, found_o, exp_found);
    if (exp_found) check({tag, "_nonce"}, nonce_o, exp_nonce);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_msgs"}, 32'(issued), 32'(exp_msgs));
    check({tag, "_collected"}, 32'(collected), 32'(issued));
    @(negedge clk_i);
    check({tag, "_found_stable"}, found_o, exp_found);
    if (!done_o) do_reset({tag, "_recover"});
  endtask

  initial begin
    logic [31:0] base, count;
    int          nh, cyc;

    reset_i = 1'b0;
    start_i = 1'b0;
    ready_i = 1'b0;
    v_i = 1'b0;
    header_i = '0;
    nonce_start_i = '0;
    nonce_count_i = '0;
    target_i = '0;
    data_i = '0;
    new_target();
    do_reset("reset");

    hits = {};
    run_job("basic", 32'h10, 32'd4, 1'b0);

    hits = {32'd6};
    run_job("two_batch", 32'h0, 32'd10, 1'b0);

    hits = {};
    run_job("wrap", 32'hFFFF_FFFE, 32'd4, 1'b0);

    base = $urandom;
    hits = {32'(base + 32'd5)};
    run_job("beyond_count", base, 32'd5, 1'b0);

    base = $urandom;
    hits = {32'(base + 32'd1), 32'(base + 32'd3)};
    run_job("stall_first_hit", base, 32'd8, 1'b1);

    hits = {};
    run_job("zero_count", $urandom, 32'd0, 1'b1);

    for (int t = 0; t < 20; t++) begin
      new_target();
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      count = 32'($urandom_range(0, 24));
      nh = $urandom_range(0, 2);
      hits = {};
      for (int h = 0; h < nh; h++) hits.push_back(32'(base + 32'($urandom_range(0, 27))));
      run_job("random", base, count, 1'($urandom_range(0, 1)));
    end

    // Reset during collection, then an empty job.
    hits = {};
    @(negedge clk_i);
    start_i = 1'b1;
    nonce_start_i = 32'h100;
    nonce_count_i = 32'd8;
    target_i = tgt;
    ready_i = 1'b1;
    v_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    for (cyc = 0; cyc < 50 && !(busy_o && !v_o); cyc++) @(negedge clk_i);
    check("mid_reset_collect", busy_o && !v_o, 1'b1);
    do_reset("mid_reset");
    start_i = 1'b1;
    nonce_count_i = 32'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    check("empty_done", done_o, 1'b1);
    check("empty_found", found_o, 1'b0);
    check("empty_busy", busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
